ud_button_stepper: RTL

UD_BUTTON_STEPPER -- requirements
Module: ud_button_stepper

---
 rtl/ud_button_stepper.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ud_button_stepper.sv
// ud_button_stepper: turns three raw push buttons (up, down, load) into
// one-cycle step/load pulses for an up/down counter SFR.
// Each button is synchronized and debounced.
// Holding up or down auto-repeats the step when the UD_AUTOREPEAT_EN macro is
// defined. Without the macro, every press gives exactly one step.
// Load always wins over a step in the same cycle. The step is dropped in that
// case, not delayed.
module ud_button_stepper #(
    parameter int DB_CYCLES    = 50000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic btn_ld,
    output logic incr,
    output logic decr,
    output logic ld
);

    localparam logic [19:0] DB_MAX = 20'(DB_CYCLES - 1);

`ifdef UD_AUTOREPEAT_EN
    localparam logic [27:0] RD_MAX  = 28'(REPEAT_DELAY - 1);
    localparam logic [27:0] RR_MAX  = 28'(REPEAT_RATE - 1);
    localparam logic [27:0] CNT_TOP = 28'hFFF_FFFF;
`else
    // Timing parameters have no effect in single-step builds.
    logic [27:0] unused_cfg_s;
    assign unused_cfg_s = 28'(REPEAT_DELAY) ^ 28'(REPEAT_RATE);
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FIRST    = 3'd1,
        S_WAIT_REL = 3'd4
`ifdef UD_AUTOREPEAT_EN
        ,
        S_DELAY    = 3'd2,
        S_REPEAT   = 3'd3
`endif
    } state_t;

    // Bit 0 = up, bit 1 = down, bit 2 = load.
    logic [2:0]  sync1_q, sync2_q, clean_q, clean_d;
    logic [19:0] db_cnt_q [3];
    logic [19:0] db_cnt_d [3];
    logic        ld_dly_q, ld_edge_q, ld_edge_d;
    state_t      state_q, state_d;
    logic        dir_up_q, dir_up_d;
    logic        step_s;
    logic        incr_q, decr_q, ld_q;
    logic        incr_d, decr_d, ld_d;
`ifdef UD_AUTOREPEAT_EN
    logic [27:0] rpt_cnt_q, rpt_cnt_d;
    logic        active_s, other_s;
`endif

    // Debounce: the clean level flips after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            clean_d[i]  = clean_q[i];
            db_cnt_d[i] = 20'd0;
            if (sync2_q[i] != clean_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    clean_d[i]  = sync2_q[i];
                    db_cnt_d[i] = 20'd0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 20'd1;
                end
            end else begin
                db_cnt_d[i] = 20'd0;
            end
        end
    end

    // Load edge detect: one pulse per clean rising edge of the load button.
    always_comb begin
        ld_edge_d = clean_q[2] & ~ld_dly_q;
    end

    // Step FSM: the first step, then the optional hold delay and repeat cadence.
    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        step_s   = 1'b0;
`ifdef UD_AUTOREPEAT_EN
        rpt_cnt_d = rpt_cnt_q;
        active_s  = dir_up_q ? clean_q[0] : clean_q[1];
        other_s   = dir_up_q ? clean_q[1] : clean_q[0];
`endif
        case (state_q)
            S_IDLE: begin
                if (clean_q[0] && clean_q[1]) begin
                    state_d = S_WAIT_REL;
                end else if (clean_q[0]) begin
                    state_d  = S_FIRST;
                    dir_up_d = 1'b1;
                end else if (clean_q[1]) begin
                    state_d  = S_FIRST;
                    dir_up_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FIRST: begin
                step_s = 1'b1;
`ifdef UD_AUTOREPEAT_EN
                state_d   = S_DELAY;
                rpt_cnt_d = 28'd0;
`else
                state_d = S_WAIT_REL;
`endif
            end
`ifdef UD_AUTOREPEAT_EN
            S_DELAY, S_REPEAT: begin
                if (other_s) begin
                    state_d   = S_WAIT_REL;
                    rpt_cnt_d = 28'd0;
                end else if (!active_s) begin
                    state_d   = S_IDLE;
                    rpt_cnt_d = 28'd0;
                end else if (rpt_cnt_q == ((state_q == S_DELAY) ? RD_MAX : RR_MAX)) begin
                    step_s    = 1'b1;
                    state_d   = S_REPEAT;
                    rpt_cnt_d = 28'd0;
                end else begin
                    rpt_cnt_d = (rpt_cnt_q != CNT_TOP) ? rpt_cnt_q + 28'd1 : rpt_cnt_q;
                end
            end
`endif
            S_WAIT_REL: begin
                if (!clean_q[0] && !clean_q[1]) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output pulses: load has priority and a colliding step is dropped.
    always_comb begin
        ld_d   = ld_edge_q;
        incr_d = step_s & dir_up_q & ~ld_d;
        decr_d = step_s & ~dir_up_q & ~ld_d;
    end

    // State registers: synchronizers, debouncers, FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 3'd0;
            sync2_q   <= 3'd0;
            clean_q   <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= 20'd0;
            end
            ld_dly_q  <= 1'b0;
            ld_edge_q <= 1'b0;
            state_q   <= S_IDLE;
            dir_up_q  <= 1'b0;
            incr_q    <= 1'b0;
            decr_q    <= 1'b0;
            ld_q      <= 1'b0;
`ifdef UD_AUTOREPEAT_EN
            rpt_cnt_q <= 28'd0;
`endif
        end else begin
            sync1_q   <= {btn_ld, btn_dn, btn_up};
            sync2_q   <= sync1_q;
            clean_q   <= clean_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            ld_dly_q  <= clean_q[2];
            ld_edge_q <= ld_edge_d;
            state_q   <= state_d;
            dir_up_q  <= dir_up_d;
            incr_q    <= incr_d;
            decr_q    <= decr_d;
            ld_q      <= ld_d;
`ifdef UD_AUTOREPEAT_EN
            rpt_cnt_q <= rpt_cnt_d;
`endif
        end
    end

    assign incr = incr_q;
    assign decr = decr_q;
    assign ld   = ld_q;

endmodule
